// File: rtl/fbcpu_param_core_if.sv
// RAM-side bus of the FBCPU parametrised core: address, write strobe/data,
// read data and the ready handshake that stalls memory-consuming cycles.
interface fbcpu_param_core_if #(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 10
);
    logic [ADDRESS_WIDTH-1:0] MAR;
    logic [DATA_WIDTH-1:0]    MDRIn;
    logic [DATA_WIDTH-1:0]    MDROut;
    logic                     RAMWr;
    logic                     RAMRdy;

    modport master (output MAR, output MDRIn, output RAMWr, input MDROut, input RAMRdy);
    modport slave  (input MAR, input MDRIn, input RAMWr, output MDROut, output RAMRdy);
endinterface

// File: rtl/fbcpu_param_core.sv
// Multi-cycle single-accumulator core: FETCH/CAPTURE/DECODE/EXEC loop over a
// synchronous single-port RAM, with carry flag, halt and sticky illegal status.
module fbcpu_param_core #(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    fbcpu_param_core_if.master       ram,
    output logic [ADDRESS_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0]    ACC,
    output logic                     carry,
    output logic                     halted,
    output logic                     illegal
);
    generate
        if (DATA_WIDTH != ADDRESS_WIDTH + 4) begin : g_width_check
            $error("fbcpu_param_core: DATA_WIDTH must equal ADDRESS_WIDTH + 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXEC    = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    localparam logic [3:0] OP_LOAD = 4'd0,  OP_STORE = 4'd1,  OP_ADD = 4'd2,  OP_SUB = 4'd3;
    localparam logic [3:0] OP_MUL  = 4'd4,  OP_DIV   = 4'd5,  OP_JMP = 4'd6,  OP_JZ  = 4'd7;
    localparam logic [3:0] OP_NOP  = 4'd8,  OP_HALT  = 4'd9,  OP_AND = 4'd10, OP_OR  = 4'd11;
    localparam logic [3:0] OP_XOR  = 4'd12, OP_LDI   = 4'd13, OP_JC  = 4'd14, OP_ILL = 4'd15;

    state_t                    state_r, state_nxt_s;
    logic [ADDRESS_WIDTH-1:0]  pc_r;
    logic [DATA_WIDTH-1:0]     ir_r, acc_r;
    logic                      carry_r, illegal_r;
    logic [3:0]                opc_s;
    logic [ADDRESS_WIDTH-1:0]  opa_s;
    logic [DATA_WIDTH:0]       sum_s;
    logic [2*DATA_WIDTH-1:0]   prod_s;
    logic [DATA_WIDTH-1:0]     alu_acc_s, mdrin_s;
    logic                      alu_carry_s, acc_we_s, carry_we_s, ramwr_s, halted_s;
    logic [ADDRESS_WIDTH-1:0]  mar_s;

    // Opcodes that read or write RAM at operand A and therefore need an EXEC cycle
    function automatic logic is_mem_op(input logic [3:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_MUL, OP_DIV,
            OP_AND, OP_OR, OP_XOR: is_mem_op = 1'b1;
            default:               is_mem_op = 1'b0;
        endcase
    endfunction

    assign opc_s  = ir_r[DATA_WIDTH-1 -: 4];
    assign opa_s  = ir_r[ADDRESS_WIDTH-1:0];
    assign sum_s  = {1'b0, acc_r} + {1'b0, ram.MDROut};
    assign prod_s = {{DATA_WIDTH{1'b0}}, acc_r} * {{DATA_WIDTH{1'b0}}, ram.MDROut};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; RAMRdy only matters where MDROut is consumed or RAM is written
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_FETCH:   state_nxt_s = ST_CAPTURE;
            ST_CAPTURE: if (ram.RAMRdy) state_nxt_s = ST_DECODE; else state_nxt_s = ST_CAPTURE;
            ST_DECODE: begin
                if (is_mem_op(opc_s)) begin
                    state_nxt_s = ST_EXEC;
                end else if ((opc_s == OP_HALT) || (opc_s == OP_ILL)) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_EXEC:    if (ram.RAMRdy) state_nxt_s = ST_FETCH; else state_nxt_s = ST_EXEC;
            ST_HALT:    state_nxt_s = ST_HALT;
            default:    state_nxt_s = ST_FETCH;
        endcase
    end

    // Bus outputs: combinational from state/PC/IR/ACC so reset clears them at once
    always_comb begin
        mar_s    = {ADDRESS_WIDTH{1'b0}};
        mdrin_s  = {DATA_WIDTH{1'b0}};
        ramwr_s  = 1'b0;
        halted_s = 1'b0;
        case (state_r)
            ST_FETCH, ST_CAPTURE: mar_s = pc_r;
            ST_DECODE: begin
                if (is_mem_op(opc_s)) mar_s = opa_s; else mar_s = {ADDRESS_WIDTH{1'b0}};
            end
            ST_EXEC: begin
                mar_s = opa_s;
                if ((opc_s == OP_STORE) && ram.RAMRdy) begin
                    ramwr_s = 1'b1;
                    mdrin_s = acc_r;
                end else begin
                    ramwr_s = 1'b0;
                end
            end
            ST_HALT:  halted_s = 1'b1;
            default:  mar_s = {ADDRESS_WIDTH{1'b0}};
        endcase
    end

    // ALU result for the EXEC cycle; carry is only touched by ADD/SUB/MUL/DIV
    always_comb begin
        alu_acc_s   = acc_r;
        alu_carry_s = carry_r;
        acc_we_s    = 1'b0;
        carry_we_s  = 1'b0;
        case (opc_s)
            OP_LOAD: begin alu_acc_s = ram.MDROut; acc_we_s = 1'b1; end
            OP_ADD:  begin {alu_carry_s, alu_acc_s} = sum_s; acc_we_s = 1'b1; carry_we_s = 1'b1; end
            OP_SUB: begin
                alu_acc_s   = acc_r - ram.MDROut;
                alu_carry_s = (ram.MDROut > acc_r);
                acc_we_s    = 1'b1;
                carry_we_s  = 1'b1;
            end
            OP_MUL: begin
                alu_acc_s   = prod_s[DATA_WIDTH-1:0];
                alu_carry_s = |prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
                acc_we_s    = 1'b1;
                carry_we_s  = 1'b1;
            end
            OP_DIV: begin
                if (ram.MDROut == {DATA_WIDTH{1'b0}}) begin
                    alu_acc_s   = {DATA_WIDTH{1'b1}};
                    alu_carry_s = 1'b1;
                end else begin
                    alu_acc_s   = acc_r / ram.MDROut;
                    alu_carry_s = 1'b0;
                end
                acc_we_s   = 1'b1;
                carry_we_s = 1'b1;
            end
            OP_AND:  begin alu_acc_s = acc_r & ram.MDROut; acc_we_s = 1'b1; end
            OP_OR:   begin alu_acc_s = acc_r | ram.MDROut; acc_we_s = 1'b1; end
            OP_XOR:  begin alu_acc_s = acc_r ^ ram.MDROut; acc_we_s = 1'b1; end
            default: begin acc_we_s = 1'b0; carry_we_s = 1'b0; end
        endcase
    end

    // Architectural registers: instruction capture, control transfer, ALU writeback
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r      <= {ADDRESS_WIDTH{1'b0}};
            ir_r      <= {DATA_WIDTH{1'b0}};
            acc_r     <= {DATA_WIDTH{1'b0}};
            carry_r   <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            case (state_r)
                ST_CAPTURE: begin
                    if (ram.RAMRdy) begin
                        ir_r <= ram.MDROut;
                        pc_r <= pc_r + {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                ST_DECODE: begin
                    case (opc_s)
                        OP_JMP:  pc_r <= opa_s;
                        OP_JZ:   if (acc_r == {DATA_WIDTH{1'b0}}) pc_r <= opa_s;
                        OP_JC:   if (carry_r) pc_r <= opa_s;
                        OP_LDI:  acc_r <= {{(DATA_WIDTH-ADDRESS_WIDTH){1'b0}}, opa_s};
                        OP_ILL:  illegal_r <= 1'b1;
                        OP_NOP, OP_HALT: pc_r <= pc_r;
                        default: pc_r <= pc_r;
                    endcase
                end
                ST_EXEC: begin
                    if (ram.RAMRdy) begin
                        if (acc_we_s) acc_r <= alu_acc_s;
                        if (carry_we_s) carry_r <= alu_carry_s;
                    end
                end
                default: pc_r <= pc_r;
            endcase
        end
    end

    assign ram.MAR   = mar_s;
    assign ram.MDRIn = mdrin_s;
    assign ram.RAMWr = ramwr_s;
    assign PC        = pc_r;
    assign ACC       = acc_r;
    assign carry     = carry_r;
    assign halted    = halted_s;
    assign illegal   = illegal_r;
endmodule

// File: tb/tb_fbcpu_param_core.sv
// Scoreboard bench for fbcpu_param_core: an instruction-level reference model
// predicts RAM writes, final state and cycle counts; a monitor checks them.
module tb_fbcpu_param_core;
    localparam int AW = 6;
    localparam int DW = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fbcpu_param_core_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    logic [AW-1:0] pc;
    logic [DW-1:0] acc;
    logic          carry, halted, illegal;

    fbcpu_param_core #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .ram(bus), .PC(pc), .ACC(acc),
        .carry(carry), .halted(halted), .illegal(illegal)
    );

    // Synchronous single-port RAM: read data one cycle after the address
    logic [DW-1:0] ram [64];
    always @(posedge clk) begin
        if (bus.RAMWr) ram[bus.MAR] <= bus.MDRIn;
        bus.MDROut <= ram[bus.MAR];
    end

    typedef struct { int addr; int data; } wr_t;
    typedef struct { int acc; int c; int pc; int ill; int cyc; } fin_t;
    wr_t  wq[$];
    fin_t fq[$];
    fin_t last_fin, mf;
    wr_t  mw;
    int   checks = 0, errors = 0;
    int   img[64];
    int   pat[16];
    int   edges = 0, mode = 0;
    bit   mon_en = 1'b0, done = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Instruction-level interpreter: plain integer arithmetic modulo 1024
    task automatic model_run(input int extra, input bit timed);
        int m[64];
        int p, a, c, ill, cyc, w, op, o, s, mv;
        wr_t wr;
        fin_t f;
        p = 0; a = 0; c = 0; ill = 0; cyc = 0;
        for (int i = 0; i < 64; i++) m[i] = img[i];
        for (int step = 0; step < 500; step++) begin
            w = m[p]; op = w / 64; o = w % 64; p = (p + 1) % 64;
            mv = m[o];
            if (op == 9 || op == 15) begin
                cyc += 3;
                if (op == 15) ill = 1;
                break;
            end
            if ((op <= 5) || (op >= 10 && op <= 12)) cyc += 4; else cyc += 3;
            case (op)
                0: a = mv;
                1: begin m[o] = a; wr.addr = o; wr.data = a; wq.push_back(wr); end
                2: begin s = a + mv; c = (s > 1023) ? 1 : 0; a = s % 1024; end
                3: begin c = (mv > a) ? 1 : 0; a = (a - mv + 1024) % 1024; end
                4: begin s = a * mv; c = (s > 1023) ? 1 : 0; a = s % 1024; end
                5: if (mv == 0) begin a = 1023; c = 1; end else begin a = a / mv; c = 0; end
                6: p = o;
                7: if (a == 0) p = o;
                10: a = a & mv;
                11: a = a | mv;
                12: a = a ^ mv;
                13: a = o;
                14: if (c != 0) p = o;
                default: ;
            endcase
        end
        f.acc = a; f.c = c; f.pc = p; f.ill = ill;
        f.cyc = timed ? cyc + extra : -1;
        fq.push_back(f);
        last_fin = f;
    endtask

    // RAMRdy driver, updated just after each rising edge
    initial begin
        bus.RAMRdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rst) edges++; else edges = 0;
            case (mode)
                1:       bus.RAMRdy = (($urandom % 3) != 0);
                2:       bus.RAMRdy = (edges + 1 < 16) ? (pat[edges + 1] != 0) : 1'b1;
                default: bus.RAMRdy = 1'b1;
            endcase
        end
    end

    // Monitor: pops expected writes on RAMWr and the final state on halt
    always @(negedge clk) begin
        if (mon_en && rst) begin
            if (bus.RAMWr) begin
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write addr=%0d data=%0d", bus.MAR, bus.MDRIn);
                end else begin
                    mw = wq.pop_front();
                    chk("wr_addr", int'(bus.MAR), mw.addr);
                    chk("wr_data", int'(bus.MDRIn), mw.data);
                end
            end
            if (mode == 2 && (edges + 1) >= 2 && (edges + 1) <= 5) chk("mar_capture_stall", int'(bus.MAR), 0);
            if (mode == 2 && (edges + 1) >= 7 && (edges + 1) <= 9) chk("mar_exec_stall", int'(bus.MAR), 20);
            if (halted && !done && fq.size() > 0) begin
                mf = fq.pop_front();
                chk("fin_acc", int'(acc), mf.acc);
                chk("fin_carry", int'(carry), mf.c);
                chk("fin_pc", int'(pc), mf.pc);
                chk("fin_illegal", int'(illegal), mf.ill);
                if (mf.cyc >= 0) chk("cycles", edges, mf.cyc);
                chk("pending_writes", wq.size(), 0);
                done = 1'b1;
            end
        end
    end

    task automatic reset_checks(input string tag);
        chk({tag, "_rst_mar"}, int'(bus.MAR), 0);
        chk({tag, "_rst_ramwr"}, int'(bus.RAMWr), 0);
        chk({tag, "_rst_mdrin"}, int'(bus.MDRIn), 0);
        chk({tag, "_rst_halted"}, int'(halted), 0);
        chk({tag, "_rst_pc"}, int'(pc), 0);
        chk({tag, "_rst_acc"}, int'(acc), 0);
        chk({tag, "_rst_carry"}, int'(carry), 0);
        chk({tag, "_rst_illegal"}, int'(illegal), 0);
    endtask

    task automatic clear_img();
        for (int i = 0; i < 64; i++) img[i] = 0;
    endtask

    task automatic run_prog(input int m, input int extra, input string tag);
        rst = 1'b0; mon_en = 1'b0; done = 1'b0; mode = m;
        wq.delete(); fq.delete();
        #1;
        reset_checks(tag);
        repeat (2) @(posedge clk);
        for (int i = 0; i < 64; i++) ram[i] = img[i][DW-1:0];
        model_run(extra, m != 1);
        @(negedge clk);
        rst = 1'b1; mon_en = 1'b1;
        #1 chk({tag, "_first_mar"}, int'(bus.MAR), 0);
        for (int k = 0; k < 3000 && !done; k++) @(posedge clk);
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_halt_timeout actual=not_halted expected=halted", tag);
        end else begin
            mode = 1;
            repeat (6) begin
                @(negedge clk);
                chk({tag, "_hold_halted"}, int'(halted), 1);
                chk({tag, "_hold_acc"}, int'(acc), last_fin.acc);
                chk({tag, "_hold_pc"}, int'(pc), last_fin.pc);
                chk({tag, "_hold_mar"}, int'(bus.MAR), 0);
                chk({tag, "_hold_ramwr"}, int'(bus.RAMWr), 0);
            end
        end
        mon_en = 1'b0;
    endtask

    task automatic load_p1();
        clear_img();
        img[0] = 20; img[1] = 149; img[2] = 86; img[3] = 576;
        img[20] = 1000; img[21] = 100;
    endtask

    task automatic gen_random();
        int n, op, a, sel;
        int ops[16] = '{0, 1, 2, 3, 4, 5, 10, 11, 12, 13, 8, 7, 14, 6, 2, 3};
        clear_img();
        n = $urandom_range(4, 20);
        for (int i = 0; i < n; i++) begin
            sel = $urandom_range(0, 15);
            op = ops[sel];
            if (op == 6 || op == 7 || op == 14) a = $urandom_range(i + 1, n);
            else if (op == 13 || op == 8) a = $urandom_range(0, 63);
            else a = $urandom_range(40, 63);
            img[i] = op * 64 + a;
        end
        img[n] = (($urandom % 4) == 0) ? 960 : 576;
        for (int j = 40; j < 64; j++) img[j] = (($urandom % 4) == 0) ? 0 : $urandom_range(0, 1023);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) pat[i] = 1;
        pat[2] = 0; pat[3] = 0; pat[4] = 0; pat[7] = 0; pat[8] = 0;

        // LOAD/ADD/STORE/HALT: 1100 wraps to 76 with carry, 15 cycles
        load_p1();
        run_prog(0, 0, "p1");
        chk("p1_mem22", int'(ram[22]), 76);
        chk("p1_acc", int'(acc), 76);

        // Asynchronous reset in the STORE write cycle
        load_p1();
        rst = 1'b0; mode = 0; mon_en = 1'b0;
        for (int i = 0; i < 64; i++) ram[i] = img[i][DW-1:0];
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (11) @(posedge clk);
        #2;
        chk("mid_store_ramwr", int'(bus.RAMWr), 1);
        chk("mid_store_mar", int'(bus.MAR), 22);
        chk("mid_store_mdrin", int'(bus.MDRIn), 76);
        rst = 1'b0;
        #1 reset_checks("mid_store");

        // SUB borrow, JC taken, JZ not taken
        clear_img();
        img[0] = 242; img[1] = 116; img[2] = 936; img[50] = 1;
        img[40] = 837; img[41] = 458; img[42] = 115; img[43] = 576;
        run_prog(0, 0, "p2");
        chk("p2_mem52", int'(ram[52]), 1023);
        chk("p2_pc", int'(pc), 44);

        // DIV by zero then MUL overflow
        clear_img();
        img[0] = 839; img[1] = 370; img[2] = 116; img[3] = 872; img[4] = 307; img[5] = 576;
        img[50] = 0; img[51] = 30;
        run_prog(0, 0, "p3");
        chk("p3_mem52", int'(ram[52]), 1023);
        chk("p3_acc", int'(acc), 176);

        // Stalls: 3 cycles in CAPTURE, 2 in EXEC of LOAD
        clear_img();
        img[0] = 20; img[1] = 576; img[20] = 1000;
        run_prog(2, 5, "p4");

        // PC wrap from 63 into an illegal opcode planted at address 0
        clear_img();
        img[0] = 444; img[60] = 58; img[61] = 64; img[62] = 512; img[63] = 895; img[58] = 960;
        run_prog(0, 0, "p5");
        chk("p5_acc", int'(acc), 63);
        chk("p5_illegal", int'(illegal), 1);

        for (int r = 0; r < 16; r++) begin
            gen_random();
            run_prog((r % 3 == 0) ? 0 : 1, 0, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
